mult_sequencer: RTL and testbench
=================================

Name: mult_sequencer

Overview:
- Multi-cycle unsigned 32x32->64 multiplier (MULTU) that time-shares the existing 32-bit ALU instead of adding a hardware multiplier.
- Sequences one shift-add iteration per cycle; each add runs on the ALU using its ADD opcode.
- Sits beside EX. The pipeline ALU input mux gives it the ALU while alu_own=1, and the hazard unit stalls on busy.
- The result goes to HI/LO.

Parameters:
- WIDTH, 32, operand width; must match the ALU data width.
- ALU_ADD_OP, 4'b0000, ALU control code for add.
- ITER, WIDTH, iteration count; counter width is clog2(ITER)+1.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only in IDLE
- op_a  in  WIDTH  multiplicand, sampled with start
- op_b  in  WIDTH  multiplier, sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, result valid
- hi  out  WIDTH  upper product word, held until next done
- lo  out  WIDTH  lower product word, held until next done
- alu_own  out  1  high in RUN; the pipeline mux routes the alu_* signals to the ALU
- alu_controle  out  4  ALU_ADD_OP in RUN, else 4'b0000
- alu_a  out  WIDTH  ALU input A
- alu_b  out  WIDTH  ALU input B
- alu_saida  in  WIDTH  ALU result (combinational, same cycle)

Behaviour:
- Reset: one clock edge with reset=1 forces the following.
  - State goes to IDLE.
  - busy, done, alu_own, hi, lo, alu_a, alu_b, all internal registers and the counter go to 0.
  - Reset overrides any operation in progress; no done is produced for an aborted operation.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge k: mcand<=op_a, p_hi<=0, p_lo<=op_b, cnt<=0, state<=RUN.
  - start=0: stay in IDLE.
- RUN, datapath:
  - alu_a = p_hi.
  - alu_b = p_lo[0] ? mcand : 0.
  - carry = (alu_saida < p_hi), unsigned compare; this is the 33rd bit of the sum.
- RUN, each edge:
  - {p_hi,p_lo} <= {carry, alu_saida, p_lo} >> 1, with 65-bit concatenation truncated to 64 bits.
  - cnt <= cnt+1.
  - When cnt==ITER-1: state<=DONE, hi<=next p_hi, lo<=next p_lo.
- DONE: done=1 for exactly one cycle, then state<=IDLE unconditionally.
- Latency: start sampled at edge k -> done high in the cycle after edge k+ITER (k+32). The next start can be accepted at edge k+ITER+2 or later.
- start while busy (RUN or DONE): ignored, not queued. Operands are not re-sampled.
- IDLE/DONE: alu_own=0, alu_a=alu_b=0, alu_controle=0. alu_own must be valid the same cycle the state enters RUN.
- hi/lo change only on the edge entering DONE, and on reset.
- Boundary values:
  - op_b=0 or op_a=0: still 32 iterations; result 0.
  - Max operands: the carry path must produce the correct hi.

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined: start at edge k with op_a==0 or op_b==0 -> state<=DONE directly, hi<=0, lo<=0. done is high in the cycle after edge k; alu_own never asserts.
- Not defined: zero operands take the full 32-iteration path, identical to the non-zero case.

Test Plan:
- op_a=3, op_b=5, start at edge k -> done only in cycle after k+32; hi=0x00000000, lo=0x0000000F; alu_controle=0000 and alu_own=1 in all 32 RUN cycles.
- op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; confirms carry handling.
- op_a=0x00010000, op_b=0x00010000 -> hi=0x00000001, lo=0x00000000. Pulse start again at edge k+10 with op_a=7 -> ignored; result unchanged, still exactly one done.
- Start 3*5, assert reset at edge k+15 -> busy=0, hi=lo=0 next cycle, no done. Then start 2*9 -> lo=0x12, hi=0.
- op_a=0, op_b=0x1234: without the macro, done after 32 cycles with result 0. With MULT_ZERO_SKIP_EN, done in the cycle after edge k, result 0, alu_own never 1.
- Back-to-back: start 6*7, then start 0x80000000*2 at the first legal edge (k+34) -> results lo=0x2A, hi=0; then hi=0x00000001, lo=0x00000000; two done pulses 34 cycles apart.

Source files
------------

// File: rtl/mult_sequencer_if.sv
// ---------------------------------------------------------------------------
// mult_sequencer_if : request/result and ALU-borrow signals of mult_sequencer.
//   start        : request, sampled only while the sequencer is idle
//   op_a, op_b   : multiplicand / multiplier, sampled with start
//   busy         : sequencer not idle
//   done         : one-cycle pulse, hi/lo valid
//   hi, lo       : upper / lower product word, held until the next done
//   alu_own      : sequencer owns the shared ALU this cycle
//   alu_controle : ALU opcode driven while owning the ALU
//   alu_a, alu_b : ALU operands
//   alu_saida    : ALU result, combinational from alu_a/alu_b
// master = pipeline side (and ALU), slave = mult_sequencer.
// ---------------------------------------------------------------------------
interface mult_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             alu_own;
    logic [3:0]       alu_controle;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_saida;

    modport master (
        output start, op_a, op_b, alu_saida,
        input  busy, done, hi, lo, alu_own, alu_controle, alu_a, alu_b
    );

    modport slave (
        input  start, op_a, op_b, alu_saida,
        output busy, done, hi, lo, alu_own, alu_controle, alu_a, alu_b
    );
endinterface

// File: rtl/mult_sequencer.sv
// ---------------------------------------------------------------------------
// mult_sequencer : unsigned WIDTH x WIDTH -> 2*WIDTH multiplier (MULTU) that
// borrows the pipeline's ALU for one shift-add step per cycle.
// Ports:
//   clock : system clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : mult_sequencer_if.slave (start/op_a/op_b in, busy/done/hi/lo out,
//           alu_own/alu_controle/alu_a/alu_b out, alu_saida in)
// Optional feature: define MULT_ZERO_SKIP_EN to finish a request with a zero
// operand directly (no ALU use, done one cycle after start).
// All outputs are registered; the next-cycle ALU operands are precomputed so
// alu_own/alu_a/alu_b are valid in the very first RUN cycle.
// ---------------------------------------------------------------------------
module mult_sequencer #(
    parameter int unsigned WIDTH      = 32,
    parameter logic [3:0]  ALU_ADD_OP = 4'b0000,
    parameter int unsigned ITER       = WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    mult_sequencer_if.slave    bus
);

    localparam int unsigned CNT_W = $clog2(ITER) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_mcand,   w_mcand_nxt;
    logic [WIDTH-1:0]   r_p_hi,    w_p_hi_nxt;
    logic [WIDTH-1:0]   r_p_lo,    w_p_lo_nxt;
    logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
    logic [WIDTH-1:0]   r_hi,      w_hi_nxt;
    logic [WIDTH-1:0]   r_lo,      w_lo_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_done,    w_done_nxt;
    logic               r_alu_own, w_alu_own_nxt;
    logic [3:0]         r_alu_ctl, w_alu_ctl_nxt;
    logic [WIDTH-1:0]   r_alu_a,   w_alu_a_nxt;
    logic [WIDTH-1:0]   r_alu_b,   w_alu_b_nxt;

    logic               w_zero_skip;
    logic               w_carry;
    logic               w_last;
    logic [WIDTH-1:0]   w_p_hi_step;
    logic [WIDTH-1:0]   w_p_lo_step;

    // Zero-operand shortcut, only present when the feature is built in
`ifdef MULT_ZERO_SKIP_EN
    assign w_zero_skip = (bus.op_a == '0) || (bus.op_b == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    // One shift-add step: the ALU sum wraps, so a result below p_hi means carry-out
    assign w_carry     = (bus.alu_saida < r_p_hi);
    assign w_p_hi_step = {w_carry, bus.alu_saida[WIDTH-1:1]};
    assign w_p_lo_step = {bus.alu_saida[0], r_p_lo[WIDTH-1:1]};
    assign w_last      = (r_cnt == CNT_W'(ITER - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_zero_skip ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values; outputs reflect the state being entered
    always_comb begin
        w_mcand_nxt   = r_mcand;
        w_p_hi_nxt    = r_p_hi;
        w_p_lo_nxt    = r_p_lo;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_done_nxt    = (w_state_nxt == S_DONE);
        w_alu_own_nxt = (w_state_nxt == S_RUN);
        w_alu_ctl_nxt = (w_state_nxt == S_RUN) ? ALU_ADD_OP : 4'b0000;
        w_alu_a_nxt   = '0;
        w_alu_b_nxt   = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_mcand_nxt = bus.op_a;
                    w_p_hi_nxt  = '0;
                    w_p_lo_nxt  = bus.op_b;
                    w_cnt_nxt   = '0;
                    if (w_zero_skip) begin
                        w_hi_nxt = '0;
                        w_lo_nxt = '0;
                    end else begin
                        // First step adds to p_hi=0
                        w_alu_b_nxt = bus.op_b[0] ? bus.op_a : '0;
                    end
                end
            end
            S_RUN: begin
                w_p_hi_nxt = w_p_hi_step;
                w_p_lo_nxt = w_p_lo_step;
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_hi_nxt = w_p_hi_step;
                    w_lo_nxt = w_p_lo_step;
                end else begin
                    w_alu_a_nxt = w_p_hi_step;
                    w_alu_b_nxt = w_p_lo_step[0] ? r_mcand : '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mcand   <= '0;
            r_p_hi    <= '0;
            r_p_lo    <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_alu_own <= 1'b0;
            r_alu_ctl <= 4'b0000;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
        end else begin
            r_mcand   <= w_mcand_nxt;
            r_p_hi    <= w_p_hi_nxt;
            r_p_lo    <= w_p_lo_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_alu_own <= w_alu_own_nxt;
            r_alu_ctl <= w_alu_ctl_nxt;
            r_alu_a   <= w_alu_a_nxt;
            r_alu_b   <= w_alu_b_nxt;
        end
    end

    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;
    assign bus.alu_own      = r_alu_own;
    assign bus.alu_controle = r_alu_ctl;
    assign bus.alu_a        = r_alu_a;
    assign bus.alu_b        = r_alu_b;

endmodule

// File: tb/tb_mult_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mult_sequencer : directed bench for mult_sequencer. A behavioural ALU
// adds alu_a+alu_b only while the sequencer owns it (junk otherwise); expected
// products are queued at start and compared when done pulses.
// Build with +define+MULT_ZERO_SKIP_EN to check the zero-skip variant.
// ---------------------------------------------------------------------------
module tb_mult_sequencer;

    localparam int unsigned WIDTH = 32;

    logic clock;
    logic reset;

    mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mult_sequencer #(
        .WIDTH      (WIDTH),
        .ALU_ADD_OP (4'b0000),
        .ITER       (WIDTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Shared ALU: sequencer's operands only while it owns the ALU
    assign bus.alu_saida = bus.alu_own ? (bus.alu_a + bus.alu_b) : 32'hDEADBEEF;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc_last = 0;
    int          done_cyc_prev = 0;
    logic [63:0] sb[$];

    // Done-pulse monitor, sampled on the rising edge (pre-update values)
    always @(posedge clock) begin
        if (bus.done === 1'b1) begin
            done_cnt      <= done_cnt + 1;
            done_cyc_prev <= done_cyc_last;
            done_cyc_last <= cyc;
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive start for one edge (edge k); returns at the negedge after edge k
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        if (push) sb.push_back(64'(a) * 64'(b));
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    // Wait for done after start at edge k; optionally re-pulse start at edge k+inj_n
    task automatic wait_done(input string tag, input int exp_lat, input int exp_own,
                             input int inj_n, input logic [31:0] inj_a);
        int          n;
        int          own_cnt;
        int          bad;
        int          dc0;
        logic [63:0] exp;
        n       = 0;
        own_cnt = 0;
        bad     = 0;
        dc0     = done_cnt;
        while (bus.done !== 1'b1 && n < 200) begin
            if (bus.alu_own === 1'b1) own_cnt++;
            if (bus.alu_controle !== 4'b0000 || bus.busy !== 1'b1) bad++;
            if (n == inj_n - 1) begin
                bus.start = 1'b1;
                bus.op_a  = inj_a;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, 64'(bus.done), 64'(1));
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_own_cycles"}, 64'(own_cnt), 64'(exp_own));
        check({tag, "_run_ctl_busy"}, 64'(bad), 64'(0));
        check({tag, "_done_own"}, 64'(bus.alu_own), 64'(0));
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
            check({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
        end else begin
            check({tag, "_scoreboard_empty"}, 64'(1), 64'(0));
        end
        @(posedge clock);
        @(negedge clock);
        check({tag, "_done_pulse_1cyc"}, 64'(bus.done), 64'(0));
        check({tag, "_busy_after"}, 64'(bus.busy), 64'(0));
        check({tag, "_done_count"}, 64'(done_cnt - dc0), 64'(1));
    endtask

    int dc_save;
    int zlat;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_own", 64'(bus.alu_own), 64'(0));
        check("rst_ctl", 64'(bus.alu_controle), 64'(0));
        check("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'(0));
        check("rst_hilo", {bus.hi, bus.lo}, 64'(0));

        // 3*5
        start_op(32'd3, 32'd5, 1'b1);
        wait_done("mul3x5", 32, 32, -1, 32'd0);

        // Max operands: exercises the carry path
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("mulmax", 32, 32, -1, 32'd0);

        // 0x10000^2 with a stray start at edge k+10 that must be ignored
        start_op(32'h0001_0000, 32'h0001_0000, 1'b1);
        wait_done("mul_ignore", 32, 32, 10, 32'd7);
        check("held_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);

        // Abort with reset at edge k+15
        start_op(32'd3, 32'd5, 1'b0);
        repeat (14) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        dc_save = done_cnt;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_own", 64'(bus.alu_own), 64'(0));
        check("abort_hilo", {bus.hi, bus.lo}, 64'(0));
        repeat (40) begin
            @(posedge clock);
            @(negedge clock);
        end
        check("abort_no_done", 64'(done_cnt - dc_save), 64'(0));
        start_op(32'd2, 32'd9, 1'b1);
        wait_done("mul2x9", 32, 32, -1, 32'd0);

        // Zero operand
`ifdef MULT_ZERO_SKIP_EN
        zlat = 0;
`else
        zlat = 32;
`endif
        start_op(32'd0, 32'h0000_1234, 1'b1);
        wait_done("mulzero", zlat, zlat, -1, 32'd0);

        // Back-to-back: second start at edge k+34
        start_op(32'd6, 32'd7, 1'b1);
        wait_done("b2b_first", 32, 32, -1, 32'd0);
        start_op(32'h8000_0000, 32'd2, 1'b1);
        wait_done("b2b_second", 32, 32, -1, 32'd0);
        check("b2b_spacing", 64'(done_cyc_last - done_cyc_prev), 64'(34));

        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
